// File: rtl/intr_req_collector_pkg.sv
// Shared definitions for the interrupt request collector.
// Holds the line count, channel-number width, bus encodings and
// the collector FSM state type.
package intr_pkg;

    localparam int unsigned NCH = 9;   // lines per bus
    localparam int unsigned CHW = 4;   // channel-number width

    typedef enum logic [1:0] {
        BUS_A = 2'd0,
        BUS_B = 2'd1,
        BUS_C = 2'd2
    } bus_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OFFER,
        CLEAR
    } state_e;

endpackage

// File: rtl/intr_req_collector_if.sv
// Service handshake between the collector and the service agent.
//   svc_valid : a granted interrupt is offered
//   svc_bus   : winning bus (0=A, 1=B, 2=C)
//   svc_chan  : winning line index
//   svc_ready : service agent accepts the offer
// master = collector side, slave = service agent side.
interface intr_req_collector_if;
    import intr_pkg::*;

    logic           svc_valid;
    logic [1:0]     svc_bus;
    logic [CHW-1:0] svc_chan;
    logic           svc_ready;

    modport master (
        output svc_valid,
        output svc_bus,
        output svc_chan,
        input  svc_ready
    );

    modport slave (
        input  svc_valid,
        input  svc_bus,
        input  svc_chan,
        output svc_ready
    );

endinterface

// File: rtl/intr_req_collector_pend_bank.sv
// Pending register for one interrupt bus.
//   clk, rst_n : clock, synchronous active-low reset
//   set        : request pulses, one bit per line
//   clr_en     : clear the line selected by clr_idx this cycle
//   clr_idx    : line to clear
//   pend       : pending bits
//   overrun    : registered pulse, a request hit an already-pending line
module intr_pend_bank
    import intr_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] set,
    input  logic           clr_en,
    input  logic [CHW-1:0] clr_idx,
    output logic [NCH-1:0] pend,
    output logic           overrun
);

    logic [NCH-1:0] clr_mask;

    // An out-of-range index shifts the single bit out, clearing nothing.
    always_comb begin
        clr_mask = '0;
        if (clr_en) begin
            clr_mask = NCH'(1) << clr_idx;
        end
    end

    // Set is applied after the clear so a same-cycle request keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            pend    <= (pend & ~clr_mask) | set;
            overrun <= |(set & pend);
        end
    end

endmodule

// File: rtl/intr_req_collector.sv
// Request-side front end for the 27-line interrupt priority arbiter.
// Captures request pulses into pending registers, presents a frozen
// snapshot to the arbiter, samples its registered grant after LAT
// cycles, offers the winner to a service agent and clears the serviced
// pending bit on acceptance.
//   clk, rst_n          : clock, synchronous active-low reset
//   irq_a/b/c           : request pulses per bus
//   en_in               : per-line enable, snapshotted to E_out
//   E_out/A_out/B_out/C_out : arbiter inputs (registered snapshot)
//   PA_in/PB_in/PC_in   : arbiter bus-grant flags
//   Chan_in             : granted line index
//   svc                 : service handshake (master side)
//   overrun             : pulse, request hit an already-pending line
//   grant_err           : pulse, malformed grant
module intr_req_collector
    import intr_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCH-1:0]              irq_a,
    input  logic [NCH-1:0]              irq_b,
    input  logic [NCH-1:0]              irq_c,
    input  logic [NCH-1:0]              en_in,
    output logic [NCH-1:0]              E_out,
    output logic [NCH-1:0]              A_out,
    output logic [NCH-1:0]              B_out,
    output logic [NCH-1:0]              C_out,
    input  logic                        PA_in,
    input  logic                        PB_in,
    input  logic                        PC_in,
    input  logic [CHW-1:0]              Chan_in,
    intr_req_collector_if.master        svc,
    output logic                        overrun,
    output logic                        grant_err
);

    localparam int unsigned WCW = (LAT == 0) ? 1 : $clog2(LAT + 1);

    state_e         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [NCH-1:0] e_d, a_d, b_d, c_d;
    bus_e           bus_q, bus_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic           gerr_d;

    logic [NCH-1:0] pend_a, pend_b, pend_c;
    logic           ovr_a, ovr_b, ovr_c;
    logic           clr_a, clr_b, clr_c;

    logic [2:0]     flags;
    logic           one_hot, none_set, chan_ok;

    assign clr_a = (state_q == CLEAR) && (bus_q == BUS_A);
    assign clr_b = (state_q == CLEAR) && (bus_q == BUS_B);
    assign clr_c = (state_q == CLEAR) && (bus_q == BUS_C);

    intr_pend_bank u_bank_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (irq_a),
        .clr_en  (clr_a),
        .clr_idx (chan_q),
        .pend    (pend_a),
        .overrun (ovr_a)
    );

    intr_pend_bank u_bank_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (irq_b),
        .clr_en  (clr_b),
        .clr_idx (chan_q),
        .pend    (pend_b),
        .overrun (ovr_b)
    );

    intr_pend_bank u_bank_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (irq_c),
        .clr_en  (clr_c),
        .clr_idx (chan_q),
        .pend    (pend_c),
        .overrun (ovr_c)
    );

    assign overrun = ovr_a | ovr_b | ovr_c;

    // Grant classification
    assign flags    = {PA_in, PB_in, PC_in};
    assign one_hot  = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign none_set = (flags == 3'b000);
    assign chan_ok  = (Chan_in < CHW'(NCH));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        e_d     = E_out;
        a_d     = A_out;
        b_d     = B_out;
        c_d     = C_out;
        bus_d   = bus_q;
        chan_d  = chan_q;
        gerr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|((pend_a | pend_b | pend_c) & en_in)) begin
                    e_d     = en_in;
                    a_d     = pend_a;
                    b_d     = pend_b;
                    c_d     = pend_c;
                    wcnt_d  = WCW'(LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end else if (one_hot && chan_ok) begin
                    bus_d   = PA_in ? BUS_A : (PB_in ? BUS_B : BUS_C);
                    chan_d  = Chan_in;
                    state_d = OFFER;
                end else if (none_set) begin
                    state_d = IDLE;
                end else begin
                    gerr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (svc.svc_ready) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            E_out     <= '0;
            A_out     <= '0;
            B_out     <= '0;
            C_out     <= '0;
            bus_q     <= BUS_A;
            chan_q    <= '0;
            grant_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            E_out     <= e_d;
            A_out     <= a_d;
            B_out     <= b_d;
            C_out     <= c_d;
            bus_q     <= bus_d;
            chan_q    <= chan_d;
            grant_err <= gerr_d;
        end
    end

    assign svc.svc_valid = (state_q == OFFER);
    assign svc.svc_bus   = bus_q;
    assign svc.svc_chan  = chan_q;

endmodule

// File: tb/tb_intr_req_collector.sv
// Directed self-checking bench for intr_req_collector. The grant
// inputs are driven as constants per round, standing in for the
// arbiter's registered outputs at the sampling edge.
module tb_intr_req_collector;
    import intr_pkg::*;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] irq_a, irq_b, irq_c, en_in;
    logic [NCH-1:0] E_out, A_out, B_out, C_out;
    logic           PA_in, PB_in, PC_in;
    logic [CHW-1:0] Chan_in;
    logic           overrun, grant_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    intr_req_collector_if svc_if ();

    intr_req_collector #(.LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_a     (irq_a),
        .irq_b     (irq_b),
        .irq_c     (irq_c),
        .en_in     (en_in),
        .E_out     (E_out),
        .A_out     (A_out),
        .B_out     (B_out),
        .C_out     (C_out),
        .PA_in     (PA_in),
        .PB_in     (PB_in),
        .PC_in     (PC_in),
        .Chan_in   (Chan_in),
        .svc       (svc_if),
        .overrun   (overrun),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_grant(input logic pa, input logic pb, input logic pc, input logic [CHW-1:0] ch);
        PA_in   = pa;
        PB_in   = pb;
        PC_in   = pc;
        Chan_in = ch;
    endtask

    task automatic check_offer(input string tag, input logic [1:0] bus, input logic [CHW-1:0] ch);
        check({tag, "_valid"}, 32'(svc_if.svc_valid), 1);
        check({tag, "_bus"},   32'(svc_if.svc_bus),   32'(bus));
        check({tag, "_chan"},  32'(svc_if.svc_chan),  32'(ch));
    endtask

    // Accept the current offer, then step through CLEAR back to IDLE.
    task automatic serve();
        svc_if.svc_ready = 1'b1;
        tick();
        svc_if.svc_ready = 1'b0;
        check("clear_valid_low", 32'(svc_if.svc_valid), 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        irq_a = '0; irq_b = '0; irq_c = '0; en_in = '0;
        set_grant(1'b0, 1'b0, 1'b0, 4'd0);
        svc_if.svc_ready = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_valid",  32'(svc_if.svc_valid), 0);
        check("rst_bus",    32'(svc_if.svc_bus),   0);
        check("rst_chan",   32'(svc_if.svc_chan),  0);
        check("rst_E",      32'(E_out), 0);
        check("rst_A",      32'(A_out), 0);
        check("rst_B",      32'(B_out), 0);
        check("rst_C",      32'(C_out), 0);
        check("rst_ovr",    32'(overrun), 0);
        check("rst_gerr",   32'(grant_err), 0);
        check("rst_pend",   32'(dut.pend_a | dut.pend_b | dut.pend_c), 0);

        // Single request B/3, check latency of every stage
        en_in = 9'h1FF;
        set_grant(1'b0, 1'b1, 1'b0, 4'd3);
        irq_b = 9'h008;
        tick();
        irq_b = '0;
        check("t1_pend_b", 32'(dut.pend_b), 'h008);
        check("t1_valid0", 32'(svc_if.svc_valid), 0);
        tick();
        check("t1_snapB", 32'(B_out), 'h008);
        check("t1_snapE", 32'(E_out), 'h1FF);
        check("t1_snapA", 32'(A_out), 0);
        ticks(2);
        check("t1_valid3", 32'(svc_if.svc_valid), 0);
        tick();
        check_offer("t1_offer", 2'd1, 4'd3);
        serve();
        check("t1_pend_b_clr", 32'(dut.pend_b), 0);

        // No grant flag: round dropped silently and retried
        set_grant(1'b0, 1'b0, 1'b0, 4'd0);
        irq_c = 9'h001;
        tick();
        irq_c = '0;
        ticks(4);
        check("none_valid", 32'(svc_if.svc_valid), 0);
        check("none_gerr",  32'(grant_err), 0);
        set_grant(1'b0, 1'b0, 1'b1, 4'd0);
        ticks(4);
        check_offer("none_retry", 2'd2, 4'd0);
        serve();
        check("none_pend_c", 32'(dut.pend_c), 0);

        // A/0 and C/8 together; A wins first, C in the next round
        set_grant(1'b1, 1'b0, 1'b0, 4'd0);
        irq_a = 9'h001;
        irq_c = 9'h100;
        tick();
        irq_a = '0;
        irq_c = '0;
        tick();
        check("t2_snapA", 32'(A_out), 'h001);
        check("t2_snapC", 32'(C_out), 'h100);
        en_in = '0;
        ticks(3);
        check_offer("t2_offerA", 2'd0, 4'd0);
        check("t2_E_frozen", 32'(E_out), 'h1FF);
        tick();
        check_offer("t2_holdA", 2'd0, 4'd0);
        en_in = 9'h1FF;
        set_grant(1'b0, 1'b0, 1'b1, 4'd8);
        serve();
        check("t2_pend_a", 32'(dut.pend_a), 0);
        check("t2_pend_c", 32'(dut.pend_c), 'h100);
        tick();
        check("t2_snapC2", 32'(C_out), 'h100);
        check("t2_snapA2", 32'(A_out), 0);
        ticks(3);
        check_offer("t2_offerC", 2'd2, 4'd8);
        serve();
        check("t2_pend_c_clr", 32'(dut.pend_c), 0);

        // Overrun on A/5: one pulse, one offer
        set_grant(1'b1, 1'b0, 1'b0, 4'd5);
        irq_a = 9'h020;
        tick();
        check("t3_ovr0", 32'(overrun), 0);
        tick();
        irq_a = '0;
        check("t3_ovr1", 32'(overrun), 1);
        tick();
        check("t3_ovr2", 32'(overrun), 0);
        ticks(2);
        check_offer("t3_offer", 2'd0, 4'd5);
        serve();
        check("t3_pend_a", 32'(dut.pend_a), 0);
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            check("t3_no_second", 32'(svc_if.svc_valid), 0);
        end

        // Request on A/2 during its own CLEAR: set wins, re-offered
        set_grant(1'b1, 1'b0, 1'b0, 4'd2);
        irq_a = 9'h004;
        tick();
        irq_a = '0;
        ticks(4);
        check_offer("t4_offer1", 2'd0, 4'd2);
        svc_if.svc_ready = 1'b1;
        tick();
        svc_if.svc_ready = 1'b0;
        irq_a = 9'h004;
        tick();
        irq_a = '0;
        check("t4_pend_kept", 32'(dut.pend_a), 'h004);
        check("t4_ovr", 32'(overrun), 1);
        tick();
        check("t4_valid_gap", 32'(svc_if.svc_valid), 0);
        ticks(3);
        check_offer("t4_offer2", 2'd0, 4'd2);
        serve();
        check("t4_pend_clr", 32'(dut.pend_a), 0);

        // Malformed grants: two flags, then Chan out of range
        set_grant(1'b1, 1'b0, 1'b1, 4'd1);
        irq_a = 9'h002;
        tick();
        irq_a = '0;
        ticks(3);
        check("t5_gerr_pre", 32'(grant_err), 0);
        tick();
        check("t5_gerr_2flag", 32'(grant_err), 1);
        check("t5_valid", 32'(svc_if.svc_valid), 0);
        check("t5_pend_kept", 32'(dut.pend_a), 'h002);
        set_grant(1'b1, 1'b0, 1'b0, 4'd12);
        tick();
        check("t5_gerr_once", 32'(grant_err), 0);
        check("t5_resnap", 32'(A_out), 'h002);
        ticks(3);
        check("t5_gerr_chan", 32'(grant_err), 1);
        check("t5_valid2", 32'(svc_if.svc_valid), 0);
        set_grant(1'b1, 1'b0, 1'b0, 4'd1);
        ticks(4);
        check_offer("t5_offer", 2'd0, 4'd1);

        // Reset while offering with ready low
        irq_b = 9'h010;
        tick();
        irq_b = '0;
        check("t6_still_valid", 32'(svc_if.svc_valid), 1);
        check("t6_pend_b", 32'(dut.pend_b), 'h010);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", 32'(svc_if.svc_valid), 0);
        check("t6_bus",   32'(svc_if.svc_bus), 0);
        check("t6_chan",  32'(svc_if.svc_chan), 0);
        check("t6_A",     32'(A_out), 0);
        check("t6_E",     32'(E_out), 0);
        check("t6_pend",  32'(dut.pend_a | dut.pend_b | dut.pend_c), 0);
        tick();
        check("t6_idle", 32'(svc_if.svc_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
